right_circ_shift: RTL and testbench

- Dual right-rotate unit for the SIMON64/96 key schedule datapath.
- Produces a rotate-right-by-1 and a rotate-right-by-3 of one input word in the same cycle.
- Both results are registered, and a valid flag travels alongside them.
- Sits between the key-word register file and the key-expansion XOR network.

---
 rtl/right_circ_shift.sv | 56 +++++
 tb/tb_right_circ_shift.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/right_circ_shift.sv
// right_circ_shift
//   Dual right-rotate unit for the SIMON64/96 key schedule. One input word is
//   rotated right by 1 and by 3 in the same cycle, and both results are
//   registered together with a valid flag (latency 1, one word per cycle).
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous, active-high reset
//   in_valid        qualifies `in` for the current cycle
//   in   [N-1:0]    word to rotate
//   shift_one_out   registered ROR(in, 1)
//   shift_three_out registered ROR(in, 3)
//   out_valid       high when both shift outputs hold a fresh result
//
// There is no backpressure: a result is valid for exactly the cycle after issue,
// while the data registers keep the last result when no new word arrives.
module right_circ_shift #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in,
    output logic [N-1:0] shift_one_out,
    output logic [N-1:0] shift_three_out,
    output logic         out_valid
);

    // Rotate amounts are fixed, so a width below 4 would leave ROR3 ill-formed.
    if (N < 4) begin : gen_width_check
        $error("right_circ_shift: N must be >= 4");
    end

    logic [N-1:0] rorOne;
    logic [N-1:0] rorThree;

    // Pure wiring: the low bits wrap around to the top, nothing is discarded.
    assign rorOne   = {in[0],   in[N-1:1]};
    assign rorThree = {in[2:0], in[N-1:3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_one_out   <= '0;
            shift_three_out <= '0;
            out_valid       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Both outputs load on the same edge from the same sample.
            if (in_valid) begin
                shift_one_out   <= rorOne;
                shift_three_out <= rorThree;
            end
        end
    end

endmodule

// File: tb/tb_right_circ_shift.sv
module tb_right_circ_shift;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        v16 = 1'b0;
    logic [15:0] in16 = '0;
    logic [15:0] one16, three16;
    logic        ov16;

    logic        v32 = 1'b0;
    logic [31:0] in32 = '0;
    logic [31:0] one32, three32;
    logic        ov32;

    int tests  = 0;
    int failed = 0;

    right_circ_shift #(.N(16)) dut16 (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (v16),
        .in             (in16),
        .shift_one_out  (one16),
        .shift_three_out(three16),
        .out_valid      (ov16)
    );

    right_circ_shift #(.N(32)) dut32 (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (v32),
        .in             (in32),
        .shift_one_out  (one32),
        .shift_three_out(three32),
        .out_valid      (ov32)
    );

    always #5 clk = ~clk;

    // Bit-by-bit reference rotate: out[i] = x[(i+s) mod w].
    function automatic logic [31:0] rorRef(logic [31:0] x, int w, int s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = x[(i + s) % w];
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(string tag, logic [15:0] e1, logic [15:0] e3, logic ev);
        chk({tag, ".one"},   {16'h0, one16},   {16'h0, e1});
        chk({tag, ".three"}, {16'h0, three16}, {16'h0, e3});
        chk({tag, ".valid"}, {31'h0, ov16},    {31'h0, ev});
    endtask

    logic [31:0] exp1_16, exp3_16, exp1_32, exp3_32;
    logic        expV16, expV32;

    initial begin
        // Load something non-zero so the async reset has work to do.
        step();
        v16 = 1'b1; in16 = 16'h1234;
        step();
        chk16("preload", 16'h091A, 16'h8246, 1'b1);

        // Assert reset between edges; outputs must clear before the next edge.
        #2 rst = 1'b1;
        #1;
        chk16("async_rst", 16'h0000, 16'h0000, 1'b0);
        chk("async_rst.valid32", {31'h0, ov32}, 32'h0);
        step();
        #2 rst = 1'b0; v16 = 1'b0;
        step();
        chk16("post_rst_idle", 16'h0000, 16'h0000, 1'b0);

        // First valid word after release.
        v16 = 1'b1; in16 = 16'hA48F;
        step();
        chk16("a48f", 16'hD247, 16'hF491, 1'b1);

        // Back-to-back stream.
        in16 = 16'hF0F0; step(); chk16("f0f0", 16'h7878, 16'h1E1E, 1'b1);
        in16 = 16'hCCCC; step(); chk16("cccc", 16'h6666, 16'h9999, 1'b1);
        in16 = 16'hF1F1; step(); chk16("f1f1", 16'hF8F8, 16'h3E3E, 1'b1);

        // Drop valid: data holds, valid clears; input change must be ignored.
        v16 = 1'b0; in16 = 16'h5555; step();
        chk16("hold", 16'hF8F8, 16'h3E3E, 1'b0);
        step();
        chk16("hold2", 16'hF8F8, 16'h3E3E, 1'b0);

        v16 = 1'b1;
        in16 = 16'h0000; step(); chk16("zeros", 16'h0000, 16'h0000, 1'b1);
        in16 = 16'hFFFF; step(); chk16("ones",  16'hFFFF, 16'hFFFF, 1'b1);
        in16 = 16'h0001; step(); chk16("lsb",   16'h8000, 16'h2000, 1'b1);
        in16 = 16'h8000; step(); chk16("msb",   16'h4000, 16'h1000, 1'b1);
        v16 = 1'b0;

        // 32-bit instance.
        v32 = 1'b1; in32 = 32'h0000_0007; step();
        chk("w32.one",   one32,   32'h8000_0003);
        chk("w32.three", three32, 32'hE000_0000);
        chk("w32.valid", {31'h0, ov32}, 32'h1);
        v32 = 1'b0; step();

        // Random stimulus on both widths against the reference model.
        exp1_16 = {16'h0, one16};  exp3_16 = {16'h0, three16};
        exp1_32 = one32;           exp3_32 = three32;
        for (int k = 0; k < 40; k++) begin
            v16 = 1'($urandom_range(0, 3) != 0);
            in16 = 16'($urandom);
            v32 = 1'($urandom_range(0, 3) != 0);
            in32 = $urandom;
            expV16 = v16;
            expV32 = v32;
            if (v16) begin
                exp1_16 = rorRef({16'h0, in16}, 16, 1);
                exp3_16 = rorRef({16'h0, in16}, 16, 3);
            end
            if (v32) begin
                exp1_32 = rorRef(in32, 32, 1);
                exp3_32 = rorRef(in32, 32, 3);
            end
            step();
            chk("rnd16.one",   {16'h0, one16},   exp1_16);
            chk("rnd16.three", {16'h0, three16}, exp3_16);
            chk("rnd16.valid", {31'h0, ov16},    {31'h0, expV16});
            chk("rnd32.one",   one32,            exp1_32);
            chk("rnd32.three", three32,          exp3_32);
            chk("rnd32.valid", {31'h0, ov32},    {31'h0, expV32});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
